xarbiter_wrr_pkt: RTL and testbench
===================================

Name: xarbiter_wrr_pkt

Overview:
Packet-aware weighted round-robin arbiter. It is the successor to the single-beat RR arbiter in the switch fabric. A grant is locked to its owner until the owner's end-of-packet beat. Each owner may then keep the grant for up to WEIGHT packets in a row. After that, ownership rotates round-robin to the next requester above the previous owner. It sits in front of each switch output port and drives the crossbar select.

Parameters:
REQ_N, 4, number of requesters (2..32)
WGT_W, 4, width of each per-requester weight field and of the credit counter
ID_W, $clog2(REQ_N), width of gnt_id (derived; not overridden)

Ports:
clk  input  1  clock
rstn  input  1  reset; synchronous, active-low
req  input  REQ_N  per-requester beat valid
last  input  REQ_N  per-requester end-of-packet flag; qualified by req
weight  input  REQ_N*WGT_W  packets per turn, field i = weight[i*WGT_W +: WGT_W]; quasi-static; 0 treated as 1
ready  input  1  downstream accepts the current beat
gnt  output  REQ_N  one-hot0 grant; combinational from state and req
gnt_id  output  ID_W  binary index of gnt; 0 when gnt==0
busy  output  1  registered; 1 in PKT or HOLD

Behaviour:
- fire = ready & |gnt. A beat transfers only on fire. req/last must stay stable until fire (requester obligation; asserted in sim).
- State register: st in {IDLE, PKT, HOLD}. owner[ID_W]. credit[WGT_W]. rr_mask[REQ_N].
- Reset (rstn=0 at posedge): st=IDLE, owner=0, credit=0, rr_mask=all-ones, busy=0. gnt and gnt_id are forced to 0 while rstn=0. Reset mid-packet abandons the packet, with no further grant until requests are re-evaluated in IDLE.
- Round-robin pick pick(req): the lowest set bit of req&rr_mask; if none, the lowest set bit of req. Zero latency.
- IDLE:
  - gnt = pick(req).
  - On fire, owner = granted index and credit = max(weight[owner],1)-1.
  - If last[owner] on that fire: go to HOLD if credit!=0, otherwise release.
  - If not last: go to PKT.
- PKT:
  - gnt = onehot(owner) & req. Other requesters are ignored.
  - If req[owner] drops, gnt=0 and the state is held (bubble allowed).
  - On fire with last[owner]: go to HOLD if credit!=0, otherwise release.
- HOLD:
  - If req[owner]=1: gnt=onehot(owner). On fire, credit-=1 and the next state is PKT or HOLD/release as above.
  - If req[owner]=0: the turn is forfeited in the same cycle. gnt=pick(req) with rr_mask already advanced past owner, the IDLE rules apply, and credit is discarded.
- Release: st=IDLE. rr_mask = bits strictly above owner (owner=REQ_N-1 gives all-zero, which falls back to all requesters, i.e. wrap-around).
- A single-beat packet (req&last on the first fire) never enters PKT.
- A simultaneous release and a new request from a higher-index requester are granted in the next cycle, not the same cycle. Only the HOLD-forfeit path is same-cycle.
- weight sampling:
  - The owner's weight is sampled only on the first fire of a turn.
  - A weight change mid-turn takes effect on the next turn.
  - Credit arithmetic is unsigned WGT_W bits and never underflows, because decrement happens only when credit!=0.
- Assertions (non-SYNTHESIS): $onehot0(gnt); gnt!=0 implies req&gnt!=0; in PKT, gnt has no bit other than owner.

Decomposition:
- Package xarb_pkg:
  - typedef arb_st_e {IDLE, PKT, HOLD}.
  - function onehot2bin.
  - localparam WGT_MIN=1.
- Sub-module xarb_rr_pick (combinational, REQ_N param; inputs req, rr_mask; output one-hot pick), instanced once.
- Top module holds the FSM, credit counter, owner, rr_mask and assertions.

Test Plan:
- Reset then idle, REQ_N=4, req=0000 held 5 cycles -> gnt=0000, gnt_id=0, busy=0 throughout; assert rstn=0 mid-packet -> gnt=0 next cycle, st=IDLE.
- Single-beat RR, weight all 1, req=1111, last=1111, ready=1 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... (wrap verified).
- Packet lock, weight=1:
  - req0 sends a 3-beat packet (last on beat 3) while req2 is asserted throughout -> gnt=0001 for 3 fires, then 0100.
  - ready=0 for 2 cycles mid-packet -> gnt held at 0001, no advance.
- Weighted: weight0=3, weight1=1, both continuously sending 1-beat packets -> gnt pattern 0001,0001,0001,0010, repeating.
- HOLD forfeit: weight0=4, req0 sends one packet then drops req while req3=1 -> gnt=1000 in the first HOLD cycle (same cycle), and later rotation starts above requester 3.
- Weight 0 and gaps:
  - weight2=0 -> behaves as 1 (one packet per turn).
  - In PKT with req[owner] deasserted for 1 cycle -> gnt=0000, busy=1, owner retained, packet resumes.

Source files
------------

// File: rtl/xarbiter_wrr_pkt_pkg.sv
// xarb_pkg: shared types, constants and helpers for the packet-aware WRR arbiter
package xarb_pkg;
    typedef enum logic [1:0] {IDLE, PKT, HOLD} arb_st_e;
    localparam int WGT_MIN = 1;
    function automatic logic [4:0] onehot2bin(input logic [31:0] oh);
        logic [4:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) b |= oh[i] ? 5'(i) : 5'd0;
        return b;
    endfunction
endpackage

// File: rtl/xarbiter_wrr_pkt_if.sv
// xarbiter_wrr_pkt_if: requester/downstream handshake bundle seen by the arbiter
interface xarbiter_wrr_pkt_if #(
    parameter int REQ_N = 4,
    parameter int WGT_W = 4,
    parameter int ID_W  = $clog2(REQ_N)
);
    import xarb_pkg::*;
    logic [REQ_N-1:0]       req;
    logic [REQ_N-1:0]       last;
    logic [REQ_N*WGT_W-1:0] weight;
    logic                   ready;
    logic [REQ_N-1:0]       gnt;
    logic [ID_W-1:0]        gnt_id;
    logic                   busy;
    modport master (output req, last, weight, ready, input gnt, gnt_id, busy);
    modport slave  (input req, last, weight, ready, output gnt, gnt_id, busy);
endinterface

// File: rtl/xarbiter_wrr_pkt_rr_pick.sv
// xarb_rr_pick: lowest requester inside the rotation mask, else lowest requester overall
module xarb_rr_pick
    import xarb_pkg::*;
#(
    parameter int REQ_N = 4
) (
    input  logic [REQ_N-1:0] req,
    input  logic [REQ_N-1:0] rr_mask,
    output logic [REQ_N-1:0] pick
);
    logic [REQ_N-1:0] masked, src;
    // Empty masked set wraps around to the full request vector.
    always_comb begin
        masked = req & rr_mask;
        src    = |masked ? masked : req;
        pick   = src & (~src + REQ_N'(1));
    end
endmodule

// File: rtl/xarbiter_wrr_pkt.sv
// xarbiter_wrr_pkt: packet-locked weighted round-robin arbiter driving the crossbar select
module xarbiter_wrr_pkt
    import xarb_pkg::*;
#(
    parameter int REQ_N = 4,
    parameter int WGT_W = 4,
    localparam int ID_W = $clog2(REQ_N)
) (
    input logic clk,
    input logic rstn,
    xarbiter_wrr_pkt_if.slave bus
);
    arb_st_e          st, st_n;
    logic [ID_W-1:0]  owner, owner_n, gid;
    logic [WGT_W-1:0] credit, credit_n, wsel;
    logic [REQ_N-1:0] rr_mask, rr_mask_n, own_oh, above, rel, pick_mask, pick, gnt;
    logic             busy, own_req, forfeit, new_turn, fire, gl;

    // Requesters strictly above the current owner: the mask a forfeited turn rotates to.
    always_comb begin
        for (int i = 0; i < REQ_N; i++) above[i] = i > int'(owner);
    end

    // Requesters strictly above the granted index: the mask a normal release rotates to.
    always_comb begin
        for (int i = 0; i < REQ_N; i++) rel[i] = i > int'(gid);
    end

    // Turn status: a HOLD whose owner stopped requesting forfeits and re-arbitrates this cycle.
    always_comb begin
        own_oh    = REQ_N'(1) << owner;
        own_req   = bus.req[owner];
        forfeit   = (st == HOLD) && !own_req;
        new_turn  = (st == IDLE) || forfeit;
        pick_mask = forfeit ? above : rr_mask;
    end

    xarb_rr_pick #(.REQ_N(REQ_N)) u_pick (.req(bus.req), .rr_mask(pick_mask), .pick(pick));

    // Grant: round-robin on a new turn, otherwise locked to the owner (gated by req inside a packet).
    always_comb begin
        gnt  = !rstn ? '0 : new_turn ? pick : (st == PKT) ? own_oh & bus.req : own_oh;
        gid  = ID_W'(onehot2bin(32'(gnt)));
        fire = bus.ready && |gnt;
        wsel = bus.weight[gid*WGT_W +: WGT_W];
        gl   = bus.last[gid];
    end

    // Turn bookkeeping: load credit on a turn's first fire, spend one per extra packet, rotate on release.
    always_comb begin
        st_n      = forfeit ? IDLE : st;
        owner_n   = owner;
        credit_n  = credit;
        rr_mask_n = forfeit ? above : rr_mask;
        if (fire) begin
            owner_n   = gid;
            credit_n  = new_turn ? ((wsel > WGT_W'(WGT_MIN)) ? wsel - WGT_W'(WGT_MIN) : '0)
                      : (st == HOLD) ? credit - 1'b1 : credit;
            st_n      = !gl ? PKT : (credit_n != '0) ? HOLD : IDLE;
            rr_mask_n = (gl && credit_n == '0) ? rel : rr_mask_n;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st      <= IDLE;
            owner   <= '0;
            credit  <= '0;
            rr_mask <= '1;
            busy    <= 1'b0;
        end else begin
            st      <= st_n;
            owner   <= owner_n;
            credit  <= credit_n;
            rr_mask <= rr_mask_n;
            busy    <= st_n != IDLE;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.gnt_id = gid;
    assign bus.busy   = busy;

`ifndef SYNTHESIS
    logic [REQ_N-1:0] p_gnt, p_req, p_last;
    // Remember a stalled grant so the requester's hold obligation can be checked next cycle.
    always_ff @(posedge clk) begin
        p_gnt  <= (rstn && !bus.ready) ? gnt : '0;
        p_req  <= bus.req;
        p_last <= bus.last;
    end
    // Grant shape and requester stability checks.
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert ($onehot0(gnt)) else $error("gnt not one-hot0: %b", gnt);
            assert (gnt == '0 || (bus.req & gnt) != '0) else $error("gnt without req: %b", gnt);
            assert (st != PKT || (gnt & ~own_oh) == '0) else $error("gnt leaves owner in PKT: %b", gnt);
            assert ((p_gnt & ((bus.req ^ p_req) | (bus.last ^ p_last))) == '0)
                else $error("req/last changed before fire");
        end
    end
`endif
endmodule

// File: tb/tb_xarbiter_wrr_pkt.sv
// tb_xarbiter_wrr_pkt: directed and randomized check of the WRR arbiter against a turn-level model
module tb_xarbiter_wrr_pkt;
    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    xarbiter_wrr_pkt_if #(.REQ_N(N), .WGT_W(W)) bus();
    xarbiter_wrr_pkt #(.REQ_N(N), .WGT_W(W)) dut(.clk(clk), .rstn(rstn), .bus(bus));

    int errs = 0;
    int checks = 0;
    int own = -1;
    int start = 0;
    int left = 0;
    bit mid = 1'b0;
    int g_last = -1;
    bit fired = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int circ(input logic [N-1:0] r, input int s);
        for (int k = 0; k < N; k++) if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    function automatic int model_pick();
        if (!rstn) return -1;
        if (own < 0) return circ(bus.req, start);
        if (mid) return bus.req[own] ? own : -1;
        return bus.req[own] ? own : circ(bus.req, (own + 1) % N);
    endfunction

    task automatic model_step(input int g);
        int w;
        if (!rstn) begin
            own = -1; start = 0; mid = 0; left = 0;
            return;
        end
        if (own >= 0 && !mid && !bus.req[own]) begin
            start = (own + 1) % N;
            own = -1;
        end
        if (!(bus.ready && g >= 0)) return;
        if (own < 0) begin
            own = g;
            w = int'(bus.weight[g*W +: W]);
            left = (w == 0 ? 1 : w) - 1;
        end else if (!mid) left--;
        if (bus.last[g]) begin
            mid = 0;
            if (left == 0) begin
                start = (own + 1) % N;
                own = -1;
            end
        end else mid = 1;
    endtask

    task automatic cyc(input int want);
        int g;
        @(negedge clk);
        g = model_pick();
        chk("gnt", 32'(bus.gnt), g < 0 ? 32'd0 : 32'd1 << g);
        chk("gnt_id", 32'(bus.gnt_id), g < 0 ? 32'd0 : 32'(g));
        chk("busy", 32'(bus.busy), 32'(own >= 0));
        if (want >= 0) chk("dir_gnt", 32'(bus.gnt), 32'(want));
        g_last = g;
        fired = rstn && bus.ready && g >= 0;
        @(posedge clk);
        model_step(g);
        #1;
    endtask

    task automatic drv(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
        bus.req = r;
        bus.last = l;
        bus.ready = rdy;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drv('0, '0, 1'b1);
        cyc(0);
        rstn = 1'b1;
    endtask

    initial begin
        bus.weight = 16'h1111;
        drv('0, '0, 1'b1);
        cyc(-1);
        cyc(-1);
        rstn = 1'b1;
        repeat (5) cyc(0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        drv(4'b1111, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) cyc(1 << (k % 4));

        do_reset();
        drv(4'b0101, 4'b0100, 1'b1);
        cyc(4'b0001);
        cyc(4'b0001);
        drv(4'b0101, 4'b0101, 1'b0);
        cyc(4'b0001);
        cyc(4'b0001);
        drv(4'b0101, 4'b0101, 1'b1);
        cyc(4'b0001);
        drv(4'b0100, 4'b0100, 1'b1);
        cyc(4'b0100);

        do_reset();
        bus.weight = 16'h1113;
        drv(4'b0011, 4'b0011, 1'b1);
        for (int k = 0; k < 8; k++) cyc((k % 4 == 3) ? 4'b0010 : 4'b0001);

        do_reset();
        bus.weight = 16'h1114;
        drv(4'b1001, 4'b1001, 1'b1);
        cyc(4'b0001);
        drv(4'b1000, 4'b1000, 1'b1);
        cyc(4'b1000);
        drv(4'b1111, 4'b1111, 1'b1);
        cyc(4'b0001);

        do_reset();
        bus.weight = 16'h1011;
        drv(4'b0101, 4'b0101, 1'b1);
        for (int k = 0; k < 4; k++) cyc(k % 2 ? 4'b0100 : 4'b0001);

        do_reset();
        bus.weight = 16'h1111;
        drv(4'b1010, 4'b1000, 1'b1);
        cyc(4'b0010);
        drv(4'b1000, 4'b1000, 1'b1);
        cyc(4'b0000);
        chk("bubble_busy", 32'(bus.busy), 32'd1);
        drv(4'b1010, 4'b1010, 1'b1);
        cyc(4'b0010);
        drv(4'b1000, 4'b1000, 1'b1);
        cyc(4'b1000);

        do_reset();
        drv(4'b0001, 4'b0000, 1'b1);
        cyc(4'b0001);
        rstn = 1'b0;
        cyc(4'b0000);
        rstn = 1'b1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        cyc(4'b0001);
        drv(4'b0001, 4'b0001, 1'b1);
        cyc(4'b0001);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) bus.weight = 16'($urandom);
            rstn = ($urandom % 400) != 0;
            bus.ready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] || (fired && g_last == i)) begin
                    bus.req[i] = ($urandom % 3) != 0;
                    bus.last[i] = ($urandom % 3) == 0;
                end
            end
            cyc(-1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
